// File: rtl/sram_bist_initiator_pkg.sv
// Shared constants for the SRAM BIST initiator: opcodes, widths,
// nibble counts and FSM state encodings.
`include "bist_defines.sv"

package sram_bist_initiator_pkg;

    localparam int OP_W  = `BIST_OP_WIDTH;
    localparam int NIB_W = `SRAM_WRAPPER_BUS_WIDTH;
    localparam int REQ_W = `JTAG_DATA_REQ_WIDTH;
    localparam int RES_W = `JTAG_DATA_RES_WIDTH;

    localparam logic [OP_W-1:0] OP_NOP        = '0;
    localparam logic [OP_W-1:0] OP_SHIFT_ID   = `BIST_OP_SHIFT_ID;
    localparam logic [OP_W-1:0] OP_SHIFT_BSEL = `BIST_OP_SHIFT_BSEL;
    localparam logic [OP_W-1:0] OP_SHIFT_ADDR = `BIST_OP_SHIFT_ADDRESS;
    localparam logic [OP_W-1:0] OP_SHIFT_DATA = `BIST_OP_SHIFT_DATA;
    localparam logic [OP_W-1:0] OP_READ       = `BIST_OP_READ;

    localparam int ID_W   = 8;
    localparam int BSEL_W = 8;
    localparam int ADDR_W = 16;

    localparam int NIB_ID    = ID_W / NIB_W;
    localparam int NIB_BSEL  = BSEL_W / NIB_W;
    localparam int NIB_ADDR  = ADDR_W / NIB_W;
    localparam int NIB_WDATA = REQ_W / NIB_W;
    localparam int NIB_RDATA = RES_W / NIB_W;

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] SH_ID    = 4'd1;
    localparam logic [3:0] SH_BSEL  = 4'd2;
    localparam logic [3:0] SH_ADDR  = 4'd3;
    localparam logic [3:0] RD_ISSUE = 4'd4;
    localparam logic [3:0] RD_WAIT  = 4'd5;
    localparam logic [3:0] RD_DATA  = 4'd6;
    localparam logic [3:0] WR_DATA  = 4'd7;
    localparam logic [3:0] GAP      = 4'd8;

    // The wrapper needs at least two quiet cycles to settle.
    function automatic int gap_eff(int g);
        return (g < 2) ? 2 : g;
    endfunction

    function automatic logic [5:0] last_idx(int n);
        return 6'(n - 1);
    endfunction

endpackage

// File: rtl/bist_defines.sv
// Shared BIST command encodings and wrapper bus widths.
// Guarded so every consumer can include it safely.
`ifndef BIST_DEFINES_SV
`define BIST_DEFINES_SV

`define BIST_OP_WIDTH          3
`define BIST_OP_SHIFT_ID       3'd1
`define BIST_OP_SHIFT_BSEL     3'd2
`define BIST_OP_SHIFT_ADDRESS  3'd3
`define BIST_OP_SHIFT_DATA     3'd4
`define BIST_OP_READ           3'd5

`define SRAM_WRAPPER_BUS_WIDTH 4
`define JTAG_DATA_REQ_WIDTH    192
`define JTAG_DATA_RES_WIDTH    256

`endif

// File: rtl/sram_bist_initiator.sv
// Serialises one SRAM read or write into the nibble-wide BIST
// command stream and collects read data back into a 256-bit word.
module sram_bist_initiator
    import sram_bist_initiator_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [7:0]       req_id,
    input  logic [7:0]       req_bsel,
    input  logic [15:0]      req_addr,
    input  logic [REQ_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [RES_W-1:0] rsp_rdata,
    output logic [OP_W-1:0]  bist_command,
    output logic [NIB_W-1:0] bist_data,
    input  logic [NIB_W-1:0] bist_rsp_data
);

    localparam int SH_W = ID_W + BSEL_W + ADDR_W + REQ_W;

    localparam logic [5:0] ID_LAST    = last_idx(NIB_ID);
    localparam logic [5:0] BSEL_LAST  = last_idx(NIB_BSEL);
    localparam logic [5:0] ADDR_LAST  = last_idx(NIB_ADDR);
    localparam logic [5:0] WDATA_LAST = last_idx(NIB_WDATA);
    localparam logic [5:0] RDATA_LAST = last_idx(NIB_RDATA);
    localparam logic [5:0] GAP_LAST   = last_idx(gap_eff(GAP_CYCLES));

    logic [3:0]             state;
    logic [3:0]             state_n;
    logic [5:0]             cnt;
    logic [5:0]             cnt_n;
    logic                   accept;
    logic                   is_wr;
    logic                   shifting;
    logic [SH_W-1:0]        sh;
    logic [RES_W-NIB_W-1:0] rd_sh;
    logic [OP_W-1:0]        cmd_n;
    logic [NIB_W-1:0]       data_n;
    logic                   rsp_valid_n;
    logic                   rd_done;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (accept) state_n = SH_ID;
            SH_ID:    if (cnt == ID_LAST) state_n = SH_BSEL;
            SH_BSEL:  if (cnt == BSEL_LAST) state_n = SH_ADDR;
            SH_ADDR: begin
                if (cnt == ADDR_LAST)
                    state_n = is_wr ? WR_DATA : RD_ISSUE;
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT:  state_n = RD_DATA;
            RD_DATA:  if (cnt == RDATA_LAST) state_n = GAP;
            WR_DATA:  if (cnt == WDATA_LAST) state_n = GAP;
            GAP:      if (cnt == GAP_LAST) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    assign cnt_n = (state_n != state) ? 6'd0 : cnt + 6'd1;

    // Outputs are registered, so they are decoded from the next state.
    always_comb begin
        cmd_n    = OP_NOP;
        shifting = 1'b0;
        case (state_n)
            SH_ID: begin
                cmd_n    = OP_SHIFT_ID;
                shifting = 1'b1;
            end
            SH_BSEL: begin
                cmd_n    = OP_SHIFT_BSEL;
                shifting = 1'b1;
            end
            SH_ADDR: begin
                cmd_n    = OP_SHIFT_ADDR;
                shifting = 1'b1;
            end
            WR_DATA: begin
                cmd_n    = OP_SHIFT_DATA;
                shifting = 1'b1;
            end
            RD_ISSUE: cmd_n = OP_READ;
            RD_DATA:  cmd_n = OP_SHIFT_DATA;
            default:  cmd_n = OP_NOP;
        endcase
    end

    // The first nibble comes straight from the request bus; the rest
    // are streamed out of the captured frame.
    always_comb begin
        data_n = '0;
        if (shifting)
            data_n = accept ? req_id[ID_W-1 -: NIB_W]
                            : sh[SH_W-1 -: NIB_W];
    end

    assign rsp_valid_n = (state_n == GAP) && (state != GAP);
    assign rd_done     = (state == RD_DATA) && (state_n == GAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bist_command <= '0;
            bist_data    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bist_command <= cmd_n;
            bist_data    <= data_n;
            rsp_valid    <= rsp_valid_n;
            if (rd_done)
                rsp_rdata <= {rd_sh, bist_rsp_data};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_wr <= req_write;
            sh    <= {req_id, req_bsel, req_addr, req_wdata} << NIB_W;
        end else if (shifting) begin
            sh <= sh << NIB_W;
        end
        if (state == RD_DATA)
            rd_sh <= {rd_sh[RES_W-2*NIB_W-1:0], bist_rsp_data};
    end

endmodule

// File: tb/tb_sram_bist_initiator.sv
// Randomised bench for sram_bist_initiator against a behavioural
// SRAM wrapper (SR_ID 5A, 64-bit words, 8-bit address).
module tb_sram_bist_initiator;
    import sram_bist_initiator_pkg::*;

    localparam int GAP_PARAM = 0;
    localparam int GAP_N = (GAP_PARAM < 2) ? 2 : GAP_PARAM;
    localparam logic [7:0] SR_ID = 8'h5A;

    typedef struct {
        bit           wr;
        logic [7:0]   id;
        logic [7:0]   bsel;
        logic [15:0]  addr;
        logic [191:0] wd;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [7:0]       req_id;
    logic [7:0]       req_bsel;
    logic [15:0]      req_addr;
    logic [191:0]     req_wdata;
    logic             rsp_valid;
    logic [255:0]     rsp_rdata;
    logic [OP_W-1:0]  bist_command;
    logic [3:0]       bist_data;
    logic [3:0]       bist_rsp_data;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0]  mem [256];
    logic [63:0]  exp_mem [256];
    logic [255:0] last_rd = '0;

    sram_bist_initiator #(.GAP_CYCLES(GAP_PARAM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_id(req_id),
        .req_bsel(req_bsel),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .bist_command(bist_command),
        .bist_data(bist_data),
        .bist_rsp_data(bist_rsp_data)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM wrapper: commits a write once 48 data nibbles
    // were shifted and the bus returns to no-op.
    logic [7:0]   w_id = '0;
    logic [15:0]  w_addr = '0;
    logic [191:0] w_wd = '0;
    logic [255:0] w_rd = '0;
    int           w_n = 0;
    bit           w_rdm = 1'b0;

    always @(posedge clk) begin
        case (bist_command)
            OP_SHIFT_ID: begin
                w_id  <= {w_id[3:0], bist_data};
                w_n   <= 0;
                w_rdm <= 1'b0;
            end
            OP_SHIFT_ADDR: w_addr <= {w_addr[11:0], bist_data};
            OP_READ: begin
                w_rdm <= 1'b1;
                w_rd  <= (w_id == SR_ID) ? {192'b0, mem[w_addr[7:0]]} : '0;
            end
            OP_SHIFT_DATA: begin
                if (w_rdm) begin
                    w_rd <= w_rd << 4;
                end else begin
                    w_wd <= {w_wd[187:0], bist_data};
                    w_n  <= w_n + 1;
                end
            end
            OP_NOP: begin
                if (!w_rdm && w_n == 48) begin
                    if (w_id == SR_ID)
                        mem[w_addr[7:0]] <= w_wd[63:0];
                    w_n <= 0;
                end
            end
            default: ;
        endcase
    end

    assign bist_rsp_data = w_rdm ? w_rd[255:252] : 4'h0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] nib(logic [191:0] v, int n, int i);
        return v[4*(n-1-i) +: 4];
    endfunction

    // Expected bus contents in cycle k of a transaction.
    task automatic expect_at(input txn_t t, input int k,
                             output logic [OP_W-1:0] op,
                             output logic [3:0] d, output bit dchk);
        op = OP_NOP;
        d = 4'h0;
        dchk = 1'b1;
        if (k <= 2) begin
            op = OP_SHIFT_ID;
            d = nib({184'b0, t.id}, 2, k - 1);
        end else if (k <= 4) begin
            op = OP_SHIFT_BSEL;
            d = nib({184'b0, t.bsel}, 2, k - 3);
        end else if (k <= 8) begin
            op = OP_SHIFT_ADDR;
            d = nib({176'b0, t.addr}, 4, k - 5);
        end else if (t.wr) begin
            if (k <= 56) begin
                op = OP_SHIFT_DATA;
                d = nib(t.wd, 48, k - 9);
            end
        end else if (k == 9) begin
            op = OP_READ;
            dchk = 1'b0;
        end else if (k >= 11 && k <= 74) begin
            op = OP_SHIFT_DATA;
            dchk = 1'b0;
        end
    endtask

    task automatic drive(input txn_t t);
        req_write = t.wr;
        req_id = t.id;
        req_bsel = t.bsel;
        req_addr = t.addr;
        req_wdata = t.wd;
    endtask

    function automatic txn_t rnd_txn();
        txn_t r;
        r.wr = 1'($urandom % 2);
        r.id = ($urandom % 4 == 0) ? 8'($urandom) : SR_ID;
        r.bsel = 8'($urandom);
        r.addr = {8'($urandom), 8'($urandom_range(0, 7))};
        r.wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic txn_t mk(bit wr, logic [7:0] id, logic [15:0] addr,
                                logic [191:0] wd);
        txn_t r;
        r.wr = wr;
        r.id = id;
        r.bsel = 8'($urandom);
        r.addr = addr;
        r.wd = wd;
        return r;
    endfunction

    function automatic logic [255:0] exp_read(txn_t t);
        return (t.id == SR_ID) ? {192'b0, exp_mem[t.addr[7:0]]} : '0;
    endfunction

    task automatic accept_txn(input txn_t t, input txn_t nxt,
                              input bit hold);
        int w;
        w = 0;
        while (!req_ready && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("ready_wait", req_ready, 1'b1);
        drive(t);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(nxt);
        req_valid = hold;
    endtask

    task automatic run(input txn_t t, input txn_t nxt, input bit hold);
        int done;
        logic [255:0] exp_rd;
        logic [OP_W-1:0] op;
        logic [3:0] d;
        bit dchk;
        accept_txn(t, nxt, hold);
        done = t.wr ? 57 : 75;
        exp_rd = exp_read(t);
        for (int k = 1; k <= done + GAP_N; k++) begin
            expect_at(t, k, op, d, dchk);
            check($sformatf("cmd@%0d", k), bist_command, op);
            if (dchk)
                check($sformatf("data@%0d", k), bist_data, d);
            check($sformatf("rsp_valid@%0d", k), rsp_valid, k == done);
            check($sformatf("req_ready@%0d", k), req_ready,
                  k == done + GAP_N);
            if (k == done)
                check("rsp_rdata", rsp_rdata, t.wr ? last_rd : exp_rd);
            if (k < done + GAP_N) begin
                @(posedge clk);
                #1;
            end
        end
        if (t.wr) begin
            if (t.id == SR_ID)
                exp_mem[t.addr[7:0]] = t.wd[63:0];
        end else begin
            last_rd = exp_rd;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        txn_t t;
        txn_t q [$];
        logic [63:0] v;
        logic [OP_W-1:0] op;
        logic [3:0] d;
        bit dchk;
        bit seen;

        for (int i = 0; i < 256; i++) begin
            v = {$urandom, $urandom};
            mem[i] = v;
            exp_mem[i] = v;
        end

        rst_n = 1'b0;
        req_valid = 1'b0;
        drive(mk(1'b0, 8'h0, 16'h0, '0));
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd", bist_command, '0);
        check("reset_data", bist_data, 4'h0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rdata", rsp_rdata, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", req_ready, 1'b1);

        run(mk(1'b1, SR_ID, 16'h0012,
               {128'($urandom), 64'hDEADBEEF_01234567}), rnd_txn(), 1'b0);
        run(mk(1'b0, SR_ID, 16'h0012, '0), rnd_txn(), 1'b0);
        check("wr_rd_5a", rsp_rdata, {192'b0, 64'hDEADBEEF_01234567});

        run(mk(1'b0, SR_ID, 16'hABCD, '0), rnd_txn(), 1'b0);

        run(mk(1'b0, 8'h33, 16'h0012, '0), rnd_txn(), 1'b0);
        check("id_mismatch_rd", rsp_rdata, '0);
        run(mk(1'b1, 8'h33, 16'h0012, {6{$urandom}}), rnd_txn(), 1'b0);
        run(mk(1'b0, SR_ID, 16'h0012, '0), rnd_txn(), 1'b0);
        check("id_mismatch_kept", rsp_rdata, {192'b0, 64'hDEADBEEF_01234567});

        run(mk(1'b1, SR_ID, 16'hFFFF, {192{1'b1}}), rnd_txn(), 1'b0);
        run(mk(1'b0, SR_ID, 16'hFFFF, '0), rnd_txn(), 1'b0);
        check("all_ones", rsp_rdata, {192'b0, {64{1'b1}}});

        for (int i = 0; i < 20; i++)
            run(rnd_txn(), rnd_txn(), 1'b0);

        // Back-to-back with req_valid held high throughout.
        for (int i = 0; i < 5; i++)
            q.push_back(rnd_txn());
        for (int i = 0; i < 5; i++)
            run(q[i], (i < 4) ? q[i+1] : rnd_txn(), i < 4);

        // Reset in the middle of a write's data phase.
        t = mk(1'b1, SR_ID, 16'h0040, {6{$urandom}});
        accept_txn(t, rnd_txn(), 1'b0);
        for (int k = 1; k <= 30; k++) begin
            expect_at(t, k, op, d, dchk);
            check($sformatf("abort_cmd@%0d", k), bist_command, op);
            if (k < 30) begin
                @(posedge clk);
                #1;
            end
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_rd = '0;
        check("abort_cmd_next", bist_command, '0);
        check("abort_data_next", bist_data, 4'h0);
        check("abort_rdata", rsp_rdata, '0);
        check("abort_ready", req_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_valid || bist_command != OP_NOP)
                seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_quiet", seen, 1'b0);
        run(mk(1'b0, SR_ID, 16'h0040, '0), rnd_txn(), 1'b0);
        check("abort_old_value", rsp_rdata, {192'b0, exp_mem[8'h40]});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
